// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions: default widths and the write-back state encoding.
// Used by the operand reader, the write-back engine and the RAM.
package mem_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StDone  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/mem_wb_counter.sv
// Address, remaining-word and written-word counters for the write-back engine.
// Clear has priority over load, load over step.
module mem_wb_counter #(
    parameter int unsigned AddrWidth = mem_pkg::ADDR_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [AddrWidth-1:0] i_base,
    input  logic [AddrWidth-1:0] i_length,
    output logic [AddrWidth-1:0] o_addr,
    output logic [AddrWidth-1:0] o_count,
    output logic                 o_last
);

    logic [AddrWidth-1:0] r_addr;
    logic [AddrWidth-1:0] r_remaining;
    logic [AddrWidth-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_count     <= '0;
        end else if (i_load) begin
            r_addr      <= i_base;
            r_remaining <= i_length;
            r_count     <= '0;
        end else if (i_step) begin
            // Address wraps naturally modulo 2^AddrWidth.
            r_addr      <= r_addr + AddrWidth'(1);
            r_remaining <= r_remaining - AddrWidth'(1);
            r_count     <= r_count + AddrWidth'(1);
        end
    end

    assign o_addr  = r_addr;
    assign o_count = r_count;
    assign o_last  = (r_remaining == AddrWidth'(1));

endmodule

// File: rtl/mem_wb_ctrl.sv
// Write-back engine: streams result words over valid/ready into consecutive RAM locations.
// RAM access is only taken while the arbiter grants it, so no collision with the reader.
module mem_wb_ctrl #(
    parameter int unsigned DATA_WIDTH = mem_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = mem_pkg::ADDR_WIDTH
) (
    input  logic                  mc_clk,
    input  logic                  mc_reset,
    input  logic                  wb_start,
    input  logic [ADDR_WIDTH-1:0] wb_base_addr,
    input  logic [ADDR_WIDTH-1:0] wb_length,
    input  logic [DATA_WIDTH-1:0] wb_data_in,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic                  wb_grant,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_we,
    output logic                  wb_busy,
    output logic                  wb_done,
    output logic [ADDR_WIDTH-1:0] wb_count
);

    import mem_pkg::*;

    wb_state_e             r_state;
    wb_state_e             w_state_next;
    logic                  w_load;
    logic                  w_step;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] w_count;

    always_ff @(posedge mc_clk) begin
        if (!mc_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        wb_ready     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (wb_start) begin
                    w_load       = 1'b1;
                    w_state_next = (wb_length != '0) ? StWrite : StDone;
                end
            end
            StWrite: begin
                // Gating by reset keeps the RAM untouched during a reset cycle.
                wb_ready = wb_grant & mc_reset;
                if (wb_valid && wb_ready && w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign w_step = wb_valid & wb_ready;

    mem_wb_counter #(
        .AddrWidth (ADDR_WIDTH)
    ) u_counter (
        .i_clk    (mc_clk),
        .i_clear  (~mc_reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_base   (wb_base_addr),
        .i_length (wb_length),
        .o_addr   (w_addr),
        .o_count  (w_count),
        .o_last   (w_last)
    );

    assign mem_we       = w_step;
    assign mem_address  = w_addr;
    assign mem_data_out = wb_data_in;
    assign wb_busy      = (r_state != StIdle);
    assign wb_done      = (r_state == StDone);
    assign wb_count     = w_count;

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// Scoreboard bench for mem_wb_ctrl: jobs push expected RAM writes and completions into
// queues; a negedge monitor pops and compares them as the DUT writes and finishes.
module tb_mem_wb_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        int len;
        int start_cyc;
    } done_t;

    logic          mc_clk = 1'b0;
    logic          mc_reset;
    logic          wb_start;
    logic [AW-1:0] wb_base_addr;
    logic [AW-1:0] wb_length;
    logic [DW-1:0] wb_data_in;
    logic          wb_valid;
    logic          wb_ready;
    logic          wb_grant;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_out;
    logic          mem_we;
    logic          wb_busy;
    logic          wb_done;
    logic [AW-1:0] wb_count;

    mem_wb_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .mc_clk       (mc_clk),
        .mc_reset     (mc_reset),
        .wb_start     (wb_start),
        .wb_base_addr (wb_base_addr),
        .wb_length    (wb_length),
        .wb_data_in   (wb_data_in),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_grant     (wb_grant),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .mem_we       (mem_we),
        .wb_busy      (wb_busy),
        .wb_done      (wb_done),
        .wb_count     (wb_count)
    );

    always #5 mc_clk = ~mc_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int jobs_done = 0;
    int jobs_issued = 0;

    wr_t   exp_q[$];
    done_t done_q[$];
    logic [DW-1:0] ram     [256];
    logic [DW-1:0] ref_mem [256];

    always @(posedge mc_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout, expected event (cycle %0d)", name, cyc);
    endtask

    // Monitor: every RAM write and every completion is checked against the queues.
    always @(negedge mc_clk) begin
        if (mc_reset === 1'b1) begin
            chk("data_passthrough", mem_data_out, wb_data_in);
        end
        if (mem_we === 1'b1) begin
            chk("we_needs_valid_grant", {31'd0, wb_valid && wb_grant}, 32'd1);
            if (exp_q.size() == 0) begin
                fail_now("unexpected_write");
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("write_addr", {24'd0, mem_address}, {24'd0, w.a});
                chk("write_data", mem_data_out, w.d);
            end
            ram[mem_address] = mem_data_out;
            last_we_cyc = cyc;
        end
        if (wb_done === 1'b1) begin
            if (done_q.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                done_t e;
                e = done_q.pop_front();
                chk("done_count", {24'd0, wb_count}, e.len);
                chk("done_writes_left", exp_q.size(), 0);
                chk("done_cycle", cyc, (e.len == 0) ? e.start_cyc + 1 : last_we_cyc + 1);
            end
            jobs_done++;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after wb_done.
    // mode 0: valid/grant high, 1: random, 2: backpressure after the 2nd word.
    task automatic run_job(input logic [AW-1:0] base, input int len, input int mode,
                           input int abort_after, input bit fixed_data);
        logic [DW-1:0] data[$];
        int i;
        int t;
        int post;
        bit hs;
        bit v;
        bit g;
        for (int k = 0; k < len; k++) begin
            data.push_back(fixed_data ? 32'hA0 + k : $urandom);
        end
        wb_start     = 1'b1;
        wb_base_addr = base;
        wb_length    = len[AW-1:0];
        for (int k = 0; k < len; k++) begin
            logic [AW-1:0] a;
            a = base + k[AW-1:0];
            exp_q.push_back('{a: a, d: data[k]});
            if (abort_after < 0 || k < abort_after) ref_mem[a] = data[k];
        end
        done_q.push_back('{len: len, start_cyc: cyc});
        jobs_issued++;
        @(posedge mc_clk) #1;
        wb_start = 1'b0;
        i = 0;
        t = 0;
        post = 0;
        while (i < len && t < 2000) begin
            if (abort_after >= 0 && i == abort_after) begin
                mc_reset   = 1'b0;
                wb_valid   = 1'b1;
                wb_grant   = 1'b1;
                wb_data_in = $urandom;
                exp_q.delete();
                done_q.delete();
                jobs_issued--;
                @(negedge mc_clk);
                chk("abort_no_we", {31'd0, mem_we}, 32'd0);
                chk("abort_no_ready", {31'd0, wb_ready}, 32'd0);
                @(posedge mc_clk) #1;
                mc_reset = 1'b1;
                wb_valid = 1'b0;
                chk("abort_busy", {31'd0, wb_busy}, 32'd0);
                chk("abort_count", {24'd0, wb_count}, 32'd0);
                chk("abort_addr", {24'd0, mem_address}, 32'd0);
                chk("abort_done", {31'd0, wb_done}, 32'd0);
                return;
            end
            case (mode)
                0: begin v = 1'b1; g = 1'b1; end
                1: begin v = ($urandom_range(0, 3) != 0); g = ($urandom_range(0, 3) != 0); end
                default: begin
                    g = !(i >= 2 && post < 2);
                    v = !(i >= 2 && post >= 1 && post < 3);
                    if (i >= 2) post++;
                end
            endcase
            wb_valid     = v;
            wb_grant     = g;
            wb_data_in   = v ? data[i] : $urandom;
            // Starts outside IDLE must be ignored.
            wb_start     = ($urandom_range(0, 7) == 0);
            wb_base_addr = $urandom;
            wb_length    = $urandom;
            @(negedge mc_clk);
            hs = wb_valid && wb_ready;
            chk("busy_in_job", {31'd0, wb_busy}, 32'd1);
            chk("ready_eq_grant", {31'd0, wb_ready}, {31'd0, wb_grant});
            @(posedge mc_clk) #1;
            if (hs) i++;
            t++;
        end
        if (t >= 2000) fail_now("word_timeout");
        wb_valid = 1'b0;
        wb_start = 1'b0;
        wb_grant = $urandom;
        t = 0;
        while (jobs_done != jobs_issued && t < 10) begin
            @(posedge mc_clk) #1;
            t++;
        end
        if (jobs_done != jobs_issued) begin
            fail_now("done_timeout");
            jobs_done = jobs_issued;
        end
        chk("idle_busy", {31'd0, wb_busy}, 32'd0);
        chk("idle_done", {31'd0, wb_done}, 32'd0);
        chk("count_hold", {24'd0, wb_count}, len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 256; a++) begin
            ram[a]     = '0;
            ref_mem[a] = '0;
        end
        mc_reset     = 1'b0;
        wb_start     = 1'b1;
        wb_valid     = 1'b1;
        wb_grant     = 1'b1;
        wb_base_addr = 8'h33;
        wb_length    = 8'h05;
        wb_data_in   = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            @(posedge mc_clk);
            @(negedge mc_clk);
            chk("rst_ready", {31'd0, wb_ready}, 32'd0);
            chk("rst_we", {31'd0, mem_we}, 32'd0);
            chk("rst_addr", {24'd0, mem_address}, 32'd0);
            chk("rst_busy", {31'd0, wb_busy}, 32'd0);
            chk("rst_done", {31'd0, wb_done}, 32'd0);
            chk("rst_count", {24'd0, wb_count}, 32'd0);
            chk("rst_data", mem_data_out, 32'h1234_5678);
        end
        @(posedge mc_clk) #1;
        mc_reset = 1'b1;
        wb_start = 1'b0;
        wb_valid = 1'b0;
        @(posedge mc_clk) #1;

        run_job(8'h10, 4, 0, -1, 1'b1);
        run_job(8'h20, 0, 0, -1, 1'b0);
        run_job(8'h30, 4, 2, -1, 1'b0);
        run_job(8'hFE, 4, 0, -1, 1'b0);
        run_job(8'h50, 8, 0, 2, 1'b0);
        run_job(8'h40, 1, 0, -1, 1'b0);
        for (int j = 0; j < 40; j++) begin
            run_job(8'($urandom), $urandom_range(0, 12), $urandom_range(0, 2), -1, 1'b0);
        end

        @(posedge mc_clk) #1;
        for (int a = 0; a < 256; a++) begin
            chk("ram_readback", ram[a], ref_mem[a]);
        end
        chk("writes_outstanding", exp_q.size(), 0);
        chk("dones_outstanding", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
